// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file and its scoreboard.
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;

    // Bits needed to hold a count from 0 to depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Per-register busy scoreboard with a registered popcount of the busy vector.
module scoreboard_bits
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int CW       = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             flush,
    output logic [DEPTH-1:0] busy,
    output logic [CW-1:0]    busy_count
);

    logic [DEPTH-1:0] busy_next;
    logic [CW-1:0]    count_next;
    logic             issue_ok;
    logic             inc;
    logic             dec;

    // An issue aimed at the hardwired zero register claims nothing.
    always_comb begin
        issue_ok = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));
    end

    // Busy next-state: flush beats issue, issue beats writeback, else hold.
    always_comb begin
        busy_next = busy;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (flush)
                busy_next[i] = 1'b0;
            else if (issue_ok && (issue_addr == AW'(i)))
                busy_next[i] = 1'b1;
            else if (wr_en && (wr_addr == AW'(i)))
                busy_next[i] = 1'b0;
        end
        if (ZERO_REG != 0)
            busy_next[0] = 1'b0;
    end

    // Incremental count update, kept equal to popcount(busy).
    // A write to the register being issued this cycle does not decrement,
    // because the issue keeps it busy.
    always_comb begin
        inc = issue_ok && !busy[issue_addr];
        dec = wr_en && busy[wr_addr] && !(issue_ok && (issue_addr == wr_addr));
        if (flush)
            count_next = '0;
        else
            count_next = busy_count + CW'(inc) - CW'(dec);
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with write-bypassed read ports and a busy
// scoreboard that feeds the stall logic.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rs_addr,
    output logic [WIDTH-1:0] rs_data,
    input  logic [AW-1:0]    rt_addr,
    output logic [WIDTH-1:0] rt_data,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    input  logic             flush,
    output logic             rs_busy,
    output logic             rt_busy,
    output logic [AW:0]      busy_count
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             wr_ok;

    // Writes to the hardwired zero register are dropped.
    always_comb begin
        wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    end

    // Register storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read port A with same-cycle write bypass.
    always_comb begin
        rs_data = regs[rs_addr];
        if (wr_ok && (wr_addr == rs_addr))
            rs_data = wr_data;
        if ((ZERO_REG != 0) && (rs_addr == '0))
            rs_data = '0;
    end

    // Read port B with same-cycle write bypass.
    always_comb begin
        rt_data = regs[rt_addr];
        if (wr_ok && (wr_addr == rt_addr))
            rt_data = wr_data;
        if ((ZERO_REG != 0) && (rt_addr == '0))
            rt_data = '0;
    end

    // A same-cycle writeback resolves the hazard since bypass supplies data.
    always_comb begin
        rs_busy = busy[rs_addr] & ~(wr_en & (wr_addr == rs_addr));
        rt_busy = busy[rt_addr] & ~(wr_en & (wr_addr == rt_addr));
    end

    scoreboard_bits #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .CW       (AW + 1)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .flush      (flush),
        .busy       (busy),
        .busy_count (busy_count)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (32 x 32, ZERO_REG = 1).
module tb_regfile_scoreboard;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic             clk;
    logic             reset;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rs_addr;
    logic [WIDTH-1:0] rs_data;
    logic [AW-1:0]    rt_addr;
    logic [WIDTH-1:0] rt_data;
    logic             issue_en;
    logic [AW-1:0]    issue_addr;
    logic             flush;
    logic             rs_busy;
    logic             rt_busy;
    logic [AW:0]      busy_count;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rs_addr    (rs_addr),
        .rs_data    (rs_data),
        .rt_addr    (rt_addr),
        .rt_data    (rt_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .flush      (flush),
        .rs_busy    (rs_busy),
        .rt_busy    (rt_busy),
        .busy_count (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to 1 time unit after the next rising edge and clear the controls.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        issue_en = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rs_addr = 5'd2; rt_addr = 5'd7; issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
        #10;
        checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL reset_rs_data got %0h exp 0", rs_data); end
        checks++; if (rt_data !== 32'd0) begin errors++; $display("FAIL reset_rt_data got %0h exp 0", rt_data); end
        checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL reset_rs_busy got %0b exp 0", rs_busy); end
        checks++; if (rt_busy !== 1'b0) begin errors++; $display("FAIL reset_rt_busy got %0b exp 0", rt_busy); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL reset_busy_count got %0d exp 0", busy_count); end
        #2 reset = 1'b1;
    endtask

    task automatic test_write_bypass();
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'd88; rs_addr = 5'd2; rt_addr = 5'd2;
        #1;
        checks++; if (rs_data !== 32'd88) begin errors++; $display("FAIL bypass_rs got %0d exp 88", rs_data); end
        checks++; if (rt_data !== 32'd88) begin errors++; $display("FAIL bypass_rt got %0d exp 88", rt_data); end
        next_cycle();
        wr_data = 32'd89;
        #1;
        checks++; if (rs_data !== 32'd88) begin errors++; $display("FAIL write_r2 got %0d exp 88", rs_data); end
        next_cycle();
        checks++; if (rt_data !== 32'd88) begin errors++; $display("FAIL hold_r2 got %0d exp 88", rt_data); end
    endtask

    task automatic test_async_reset();
        // Mid-cycle, well away from any rising edge.
        #2;
        reset = 1'b0;
        #1;
        checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL async_reset_r2 got %0d exp 0", rs_data); end
        #1;
        reset = 1'b1;
        next_cycle();
        checks++; if (rt_data !== 32'd0) begin errors++; $display("FAIL post_reset_r2 got %0d exp 0", rt_data); end
    endtask

    task automatic test_zero_reg();
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
        issue_en = 1'b1; issue_addr = 5'd0; rs_addr = 5'd0;
        #1;
        checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL zero_bypass got %0h exp 0", rs_data); end
        next_cycle();
        checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL zero_data got %0h exp 0", rs_data); end
        checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %0b exp 0", rs_busy); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL zero_count got %0d exp 0", busy_count); end
    endtask

    task automatic test_issue_writeback();
        issue_en = 1'b1; issue_addr = 5'd5;
        next_cycle();
        issue_en = 1'b1; issue_addr = 5'd7;
        next_cycle();
        rs_addr = 5'd5; rt_addr = 5'd7;
        #1;
        checks++; if (busy_count !== 6'd2) begin errors++; $display("FAIL issue_count got %0d exp 2", busy_count); end
        checks++; if (rs_busy !== 1'b1) begin errors++; $display("FAIL issue_r5_busy got %0b exp 1", rs_busy); end
        checks++; if (rt_busy !== 1'b1) begin errors++; $display("FAIL issue_r7_busy got %0b exp 1", rt_busy); end
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd123;
        #1;
        checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL wb_same_cycle_busy got %0b exp 0", rs_busy); end
        checks++; if (rs_data !== 32'd123) begin errors++; $display("FAIL wb_same_cycle_data got %0d exp 123", rs_data); end
        checks++; if (rt_busy !== 1'b1) begin errors++; $display("FAIL wb_other_busy got %0b exp 1", rt_busy); end
        next_cycle();
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL wb_count got %0d exp 1", busy_count); end
        checks++; if (rs_data !== 32'd123) begin errors++; $display("FAIL wb_data got %0d exp 123", rs_data); end
        checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL wb_busy got %0b exp 0", rs_busy); end
    endtask

    task automatic test_back_to_back();
        issue_en = 1'b1; issue_addr = 5'd3;
        next_cycle();
        checks++; if (busy_count !== 6'd2) begin errors++; $display("FAIL r3_issue_count got %0d exp 2", busy_count); end
        issue_en = 1'b1; issue_addr = 5'd3;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd55;
        next_cycle();
        rs_addr = 5'd3;
        #1;
        checks++; if (rs_data !== 32'd55) begin errors++; $display("FAIL r3_data got %0d exp 55", rs_data); end
        checks++; if (rs_busy !== 1'b1) begin errors++; $display("FAIL r3_busy got %0b exp 1", rs_busy); end
        checks++; if (busy_count !== 6'd2) begin errors++; $display("FAIL r3_count got %0d exp 2", busy_count); end
        issue_en = 1'b1; issue_addr = 5'd3;
        next_cycle();
        checks++; if (busy_count !== 6'd2) begin errors++; $display("FAIL reissue_count got %0d exp 2", busy_count); end
    endtask

    task automatic test_flush();
        issue_en = 1'b1; issue_addr = 5'd11;
        next_cycle();
        checks++; if (busy_count !== 6'd3) begin errors++; $display("FAIL pre_flush_count got %0d exp 3", busy_count); end
        flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd9;
        next_cycle();
        rs_addr = 5'd9; rt_addr = 5'd3;
        #1;
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", busy_count); end
        checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL flush_r9_busy got %0b exp 0", rs_busy); end
        checks++; if (rt_busy !== 1'b0) begin errors++; $display("FAIL flush_r3_busy got %0b exp 0", rt_busy); end
        checks++; if (rt_data !== 32'd55) begin errors++; $display("FAIL flush_r3_data got %0d exp 55", rt_data); end
        rs_addr = 5'd5;
        #1;
        checks++; if (rs_data !== 32'd123) begin errors++; $display("FAIL flush_r5_data got %0d exp 123", rs_data); end
    endtask

    task automatic test_write_idle_reg();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd77; rs_addr = 5'd5;
        next_cycle();
        checks++; if (rs_data !== 32'd77) begin errors++; $display("FAIL idle_write_data got %0d exp 77", rs_data); end
        checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL idle_write_busy got %0b exp 0", rs_busy); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL idle_write_count got %0d exp 0", busy_count); end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_async_reset();
        test_zero_reg();
        test_issue_writeback();
        test_back_to_back();
        test_flush();
        test_write_idle_reg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised multi-register file that succeeds the single 32-bit enabled register: DEPTH words of WIDTH bits.
- Provides one write port, two combinational read ports with same-cycle write bypass, and a per-register busy scoreboard.
- The scoreboard is set by an issue request and cleared by writeback; it also keeps a busy-register counter.
- Sits in the datapath as the architectural register file plus hazard tracker feeding the stall logic.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers (power of two, >= 2).
- AW, $clog2(DEPTH), address width (derived; do not override).
- ZERO_REG, 1, when 1: register 0 always reads 0, is never written, and is never busy.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  write enable for the writeback port.
- wr_addr  input  AW  write register index.
- wr_data  input  WIDTH  write data.
- rs_addr  input  AW  read port A index.
- rs_data  output  WIDTH  read port A data (combinational).
- rt_addr  input  AW  read port B index.
- rt_data  output  WIDTH  read port B data (combinational).
- issue_en  input  1  marks issue_addr busy (new pending producer).
- issue_addr  input  AW  register being claimed.
- flush  input  1  synchronously clears all busy bits; data is untouched.
- rs_busy  output  1  port A register has a pending producer.
- rt_busy  output  1  port B register has a pending producer.
- busy_count  output  AW+1  number of registers currently busy.

Behaviour:
- Reset (reset low, asynchronous): all registers = 0, all busy bits = 0, busy_count = 0. Outputs follow combinationally: rs_data = rt_data = 0, rs_busy = rt_busy = 0.
- Write: on posedge with wr_en = 1, reg[wr_addr] <= wr_data. Ignored when ZERO_REG = 1 and wr_addr = 0.
- With wr_en = 0, registers hold their value.
- Read: combinational, zero-cycle latency. rs_data = reg[rs_addr], except:
  - bypass: if wr_en = 1, wr_addr = rs_addr and the write is not suppressed, rs_data = wr_data;
  - if ZERO_REG = 1 and rs_addr = 0, rs_data = 0.
  - Port B behaves identically.
- Scoreboard next-state per register i, priority high to low:
  1. flush: busy[i] <= 0;
  2. issue_en and issue_addr = i: busy[i] <= 1;
  3. wr_en and wr_addr = i: busy[i] <= 0;
  4. otherwise hold.
- Issue and write to the same register in one cycle leaves the register busy: the new producer wins over the old writeback.
- Issue to an already-busy register stays busy, and busy_count is unchanged.
- Writing a non-busy register is legal: data is updated and busy stays 0.
- ZERO_REG = 1: busy[0] is forced to 0, so issue to register 0 is ignored.
- Busy outputs: rs_busy = busy[rs_addr] & ~(wr_en & wr_addr = rs_addr). A same-cycle writeback resolves the hazard because bypass supplies the data. rt_busy is analogous.
- busy_count: registered. It updates on the same edge as the busy bits and always equals popcount(busy). It is recomputed incrementally:
  - +1 when an issue sets a non-busy register;
  - -1 when a write clears a busy register that is not simultaneously issued;
  - 0 after flush, even if issue_en is high that cycle (flush wins).
  - busy_count never exceeds DEPTH - ZERO_REG.
- Reset mid-operation: all state clears immediately, regardless of clk. The first edge after reset deasserts behaves like a normal cycle.
- No X propagation: out-of-range addresses are impossible because DEPTH is a power of two.

Decomposition:
- Shared package regfile_pkg: default WIDTH/DEPTH constants, and a helper function computing the count width ($clog2(DEPTH+1)).
- One natural sub-module: scoreboard_bits. It holds the busy vector, the priority logic and busy_count.
- Storage and bypass read muxes stay in the top module.

Test Plan:
- Reset low for 10 time units -> rs_data = rt_data = 0, rs_busy = 0, busy_count = 0. Pulse reset low mid-run after writing 88 to r2 -> r2 reads 0 immediately, without waiting for an edge.
- wr_en = 1, wr_addr = 2, wr_data = 88, then wr_en = 0 with wr_data = 89 -> r2 reads 88 and holds 88. During the write cycle, rs_addr = 2 reads 88 via bypass.
- ZERO_REG = 1: write 0xDEADBEEF to r0, issue r0 -> rs_data = 0, rs_busy = 0, busy_count = 0.
- Issue r5, then issue r7 -> busy_count = 2 and rs_busy(r5) = 1. Write r5 = 123 -> rs_busy drops in the same cycle, rs_data = 123, and busy_count = 1 after the edge.
- Same cycle: issue r3 and write r3 = 55 (r3 previously busy) -> after the edge r3 = 55, busy[r3] = 1, busy_count unchanged.
- Three registers busy, then flush with issue_en = 1 to r9 -> busy_count = 0, all busy = 0, register data unchanged.
